// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 state encodings, command constants and defaults
package ps2_host_tx_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAITIDLE
    } state_t;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RESP_ACK    = 8'hFA;
    localparam int DEF_CLK_HOLD = 5000;
    localparam int DEF_TIMEOUT  = 1000000;
    localparam int DEF_FILT_LEN = 8;
    // Bits shifted out after the start bit: data LSB first, odd parity, stop
    function automatic logic [9:0] tx_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: pin synchronizers, clock glitch filter and falling-edge pulse
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_filt,
    output logic dat_sync,
    output logic fall
);
    logic [1:0]          clk_s;
    logic [1:0]          dat_s;
    logic [FILT_LEN-2:0] hist;
    logic [FILT_LEN-1:0] window;
    assign window   = {hist, clk_s[1]};
    assign dat_sync = dat_s[1];
    // Idle bus is high, so everything resets to 1; filtered clock only moves on a unanimous window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            hist     <= '1;
            clk_filt <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_s    <= {clk_s[0], ps2_clk};
            dat_s    <= {dat_s[0], ps2_dat};
            hist     <= window[FILT_LEN-2:0];
            clk_filt <= (&window) ? 1'b1 : (~|window) ? 1'b0 : clk_filt;
            fall     <= clk_filt & ~|window;
        end
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter with ACK check and watchdog
import ps2_host_tx_pkg::*;
module ps2_host_tx #(
    parameter int CLK_HOLD = DEF_CLK_HOLD,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic       iCLK_50,
    input  logic       iKEY,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    input  logic       iSTART,
    input  logic [7:0] iDATA,
    output logic       oCLK_OE,
    output logic       oDAT_OE,
    output logic       oBUSY,
    output logic       oDONE,
    output logic       oERR
);
    logic        clk_filt;
    logic        dat_sync;
    logic        fall;
    state_t      state;
    logic [9:0]  shift;
    logic [3:0]  bits;
    logic [19:0] cnt;
    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk      (iCLK_50),
        .rst_n    (iKEY),
        .ps2_clk  (PS2_KBCLK),
        .ps2_dat  (PS2_KBDAT),
        .clk_filt (clk_filt),
        .dat_sync (dat_sync),
        .fall     (fall)
    );
    // Transmit sequencer; cnt is the clock-hold timer in RTS and the inter-edge watchdog afterwards
    always_ff @(posedge iCLK_50 or negedge iKEY) begin
        if (!iKEY) begin
            state   <= S_IDLE;
            shift   <= '0;
            bits    <= '0;
            cnt     <= '0;
            oCLK_OE <= 1'b0;
            oDAT_OE <= 1'b0;
            oBUSY   <= 1'b0;
            oDONE   <= 1'b0;
            oERR    <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            oERR  <= 1'b0;
            if (state == S_IDLE) begin
                if (iSTART && !oDONE && !oERR) begin
                    state   <= S_RTS;
                    oBUSY   <= 1'b1;
                    oCLK_OE <= 1'b1;
                    shift   <= tx_frame(iDATA);
                    bits    <= '0;
                    cnt     <= '0;
                end
            end else if (state == S_RTS) begin
                if (cnt == 20'(CLK_HOLD - 1)) begin
                    state   <= S_REQ;
                    oCLK_OE <= 1'b0;
                    oDAT_OE <= 1'b1;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 20'd1;
                end
            end else if (fall) begin
                cnt <= '0;
                if (state == S_REQ) begin
                    state <= S_SEND;
                end else if (state == S_SEND) begin
                    oDAT_OE <= ~shift[0];
                    shift   <= {1'b0, shift[9:1]};
                    bits    <= bits + 4'd1;
                    if (bits == 4'd9)
                        state <= S_ACK;
                end else if (state == S_ACK) begin
                    if (dat_sync) begin
                        oERR  <= 1'b1;
                        oBUSY <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_WAITIDLE;
                    end
                end
            end else if (state == S_WAITIDLE && clk_filt && dat_sync) begin
                oDONE <= 1'b1;
                oBUSY <= 1'b0;
                state <= S_IDLE;
            end else if (cnt == 20'(TIMEOUT - 1)) begin
                oERR    <= 1'b1;
                oBUSY   <= 1'b0;
                oCLK_OE <= 1'b0;
                oDAT_OE <= 1'b0;
                state   <= S_IDLE;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with an open-drain PS/2 device model
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;
    localparam int CH = 60;
    localparam int TO = 3000;
    localparam int FL = 8;
    localparam int H  = 50;

    typedef struct {
        bit          ok;
        bit          chk_frame;
        logic [10:0] frame;
    } exp_t;

    logic       iCLK_50 = 1'b0;
    logic       iKEY    = 1'b0;
    logic       iSTART  = 1'b0;
    logic [7:0] iDATA   = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       glitch      = 1'b0;
    logic       PS2_KBCLK, PS2_KBDAT;
    logic       oCLK_OE, oDAT_OE, oBUSY, oDONE, oERR;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    logic [10:0] obs_frame = '0;

    assign PS2_KBCLK = !(oCLK_OE || dev_clk_low || glitch);
    assign PS2_KBDAT = !(oDAT_OE || dev_dat_low);

    always #5 iCLK_50 = ~iCLK_50;

    ps2_host_tx #(.CLK_HOLD(CH), .TIMEOUT(TO), .FILT_LEN(FL)) dut (
        .iCLK_50  (iCLK_50),
        .iKEY     (iKEY),
        .PS2_KBCLK(PS2_KBCLK),
        .PS2_KBDAT(PS2_KBDAT),
        .iSTART   (iSTART),
        .iDATA    (iDATA),
        .oCLK_OE  (oCLK_OE),
        .oDAT_OE  (oDAT_OE),
        .oBUSY    (oBUSY),
        .oDONE    (oDONE),
        .oERR     (oERR)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2 == 0);
        return {1'b1, p, d, 1'b0};
    endfunction

    // Monitor: every completion pulse is matched against the oldest expectation
    always @(negedge iCLK_50) begin
        exp_t e;
        if (iKEY && (oDONE || oERR)) begin
            check("done_err_excl", 32'(oDONE & oERR), 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({oDONE, oERR}), 0);
            end else begin
                e = sb.pop_front();
                check("outcome", 32'({oDONE, oERR}), e.ok ? 32'd2 : 32'd1);
                check("busy_at_pulse", 32'(oBUSY), 0);
                if (e.chk_frame)
                    check("frame", 32'(obs_frame), 32'(e.frame));
            end
        end
    end

    task automatic request(input logic [7:0] d);
        int n;
        @(posedge iCLK_50); #1;
        iDATA  = d;
        iSTART = 1'b1;
        @(posedge iCLK_50); #1;
        iSTART = 1'b0;
        check("busy_rise", 32'(oBUSY), 1);
        n = 0;
        @(negedge iCLK_50);
        while (oCLK_OE && n < CH + 100) begin
            n++;
            @(negedge iCLK_50);
        end
        check("clk_hold", n, CH);
        check("rts_dat", 32'(oDAT_OE), 1);
    endtask

    task automatic dev_pulse(output logic b);
        @(posedge iCLK_50); #1;
        dev_clk_low = 1'b1;
        repeat (H) @(posedge iCLK_50);
        #1;
        b = PS2_KBDAT;
        dev_clk_low = 1'b0;
        repeat (H) @(posedge iCLK_50);
    endtask

    task automatic device_frame(input bit ack, input int gbit);
        logic b;
        logic [10:0] f;
        repeat (20) @(posedge iCLK_50);
        for (int i = 0; i < 11; i++) begin
            dev_pulse(b);
            f[i] = b;
            if (i == gbit) begin
                #1 glitch = 1'b1;
                repeat (3) @(posedge iCLK_50);
                #1 glitch = 1'b0;
                repeat (H) @(posedge iCLK_50);
            end
        end
        obs_frame = f;
        #1 dev_dat_low = ack;
        dev_pulse(b);
        #1 dev_dat_low = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (oBUSY && n < 5000) begin
            @(negedge iCLK_50);
            n++;
        end
        check("busy_drop", 32'(oBUSY), 0);
        repeat (20) @(posedge iCLK_50);
    endtask

    task automatic txn(input logic [7:0] d, input bit ack, input int gbit);
        sb.push_back('{ok: ack, chk_frame: 1'b1, frame: ref_frame(d)});
        request(d);
        device_frame(ack, gbit);
        wait_idle();
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        logic b;
        logic [7:0] d;
        #3;
        check("reset_state", 32'({oCLK_OE, oDAT_OE, oBUSY, oDONE, oERR}), 0);
        repeat (3) @(posedge iCLK_50);
        #1 iKEY = 1'b1;
        repeat (20) @(posedge iCLK_50);

        txn(CMD_SET_LED, 1'b1, -1);
        txn(8'h00, 1'b1, -1);
        txn(8'h01, 1'b1, -1);
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            txn(d, 1'b1, -1);
        end

        // Device never clocks: watchdog must fire exactly TO cycles after REQ entry
        sb.push_back('{ok: 1'b0, chk_frame: 1'b0, frame: '0});
        request(CMD_RESET);
        m = 0;
        while (!oERR && m < TO + 100) begin
            @(negedge iCLK_50);
            m++;
        end
        check("timeout_cycles", m, TO);
        check("oe_after_timeout", 32'({oCLK_OE, oDAT_OE}), 0);
        wait_idle();

        // Device leaves data high at the acknowledge edge
        txn(CMD_ENABLE, 1'b0, -1);

        // Short low glitch on the device clock after bit 4
        txn(CMD_RESET, 1'b1, 4);

        // Extra start requests while busy must be dropped
        sb.push_back('{ok: 1'b1, chk_frame: 1'b1, frame: ref_frame(CMD_ENABLE)});
        fork
            begin
                request(CMD_ENABLE);
                device_frame(1'b1, -1);
            end
            begin
                repeat (3) begin
                    repeat (300) @(posedge iCLK_50);
                    #1;
                    iSTART = 1'b1;
                    iDATA  = 8'($urandom);
                    @(posedge iCLK_50); #1;
                    iSTART = 1'b0;
                end
            end
        join
        wait_idle();
        repeat (30) @(posedge iCLK_50);
        check("no_requeue", 32'({oBUSY, oCLK_OE, oDAT_OE}), 0);

        // Asynchronous reset in the middle of bit 4
        request(8'h5A);
        repeat (20) @(posedge iCLK_50);
        for (int i = 0; i < 5; i++) dev_pulse(b);
        @(posedge iCLK_50); #1;
        dev_clk_low = 1'b1;
        repeat (H / 2) @(posedge iCLK_50);
        #2 iKEY = 1'b0;
        #1 check("async_reset", 32'({oCLK_OE, oDAT_OE, oBUSY, oDONE, oERR}), 0);
        repeat (5) @(posedge iCLK_50);
        #1 dev_clk_low = 1'b0;
        repeat (5) @(posedge iCLK_50);
        #1 iKEY = 1'b1;
        repeat (30) @(posedge iCLK_50);
        check("idle_after_reset", 32'({oCLK_OE, oDAT_OE, oBUSY}), 0);

        txn(8'hA7, 1'b1, -1);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
